// File: rtl/cia_bus_arbiter_if.sv
// Register-bus bundle between the two requesters, the arbiter and one CIA.
// The arbiter takes the slave view; the requester/CIA side takes the master view.
interface cia_bus_arbiter_if;
  // requester 0 (CPU bridge)
  logic       m0_req;
  logic       m0_rw;
  logic [3:0] m0_rs;
  logic [7:0] m0_wdata;
  logic       m0_ack;
  logic [7:0] m0_rdata;
  // requester 1 (host/debug bridge)
  logic       m1_req;
  logic       m1_rw;
  logic [3:0] m1_rs;
  logic [7:0] m1_wdata;
  logic       m1_ack;
  logic [7:0] m1_rdata;
  // CIA register port
  logic       cia_cs_n;
  logic       cia_rw;
  logic [3:0] cia_rs;
  logic [7:0] cia_db_in;
  logic [7:0] cia_db_out;

  modport slave (
    input  m0_req, m0_rw, m0_rs, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_rw, m1_rs, m1_wdata,
    output m1_ack, m1_rdata,
    output cia_cs_n, cia_rw, cia_rs, cia_db_in,
    input  cia_db_out
  );

  modport master (
    output m0_req, m0_rw, m0_rs, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_rw, m1_rs, m1_wdata,
    input  m1_ack, m1_rdata,
    input  cia_cs_n, cia_rw, cia_rs, cia_db_in,
    output cia_db_out
  );
endinterface

// File: rtl/cia_bus_arbiter.sv
// Two-requester arbiter for a single CIA register bus. One access per phi2
// slot: a single-clk chip-select strobe, a capture cycle, then a one-clk ack.

// Per-requester completion logic: ack pulse and read-data holding register.
module cia_bus_arbiter_port (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       done_i,   // capture cycle of an access owned by this port
  input  logic       rd_i,     // that access is a read
  input  logic [7:0] db_i,     // CIA read data valid in the capture cycle
  output logic       ack_o,
  output logic [7:0] rdata_o
);
  logic       ack_q;
  logic [7:0] rdata_q;

  // ack pulses for exactly one clk after capture; writes leave rdata alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ack_q <= done_i;
      if (done_i && rd_i) rdata_q <= db_i;
    end
  end

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
endmodule

module cia_bus_arbiter #(
  parameter int FIXED_PRIO = 0   // 0: round-robin, 1: m0 wins ties
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                phi2,
  cia_bus_arbiter_if.slave    bus,
  output logic                busy,
  output logic                grant_id
);
  localparam int NUM_M = 2;

  typedef enum logic [1:0] {IDLE, STROBE, CAPTURE} state_t;

  state_t     state_q, state_d;
  logic       cs_n_q, cs_n_d;
  logic       rw_q, rw_d;
  logic [3:0] rs_q, rs_d;
  logic [7:0] db_q, db_d;
  logic       gid_q, gid_d;

  logic [NUM_M-1:0]       req, rw_m, elig, ack, done;
  logic [NUM_M-1:0][3:0]  rs_m;
  logic [NUM_M-1:0][7:0]  wd_m, rdata;
  logic                   win;

  assign req  = {bus.m1_req,   bus.m0_req};
  assign rw_m = {bus.m1_rw,    bus.m0_rw};
  assign rs_m = {bus.m1_rs,    bus.m0_rs};
  assign wd_m = {bus.m1_wdata, bus.m0_wdata};

  // a requester in its ack cycle may still show req; mask it so the
  // completed access is not issued a second time
  assign elig = req & ~ack;

  // winner select: a lone request wins, ties go by priority mode
  always_comb begin
    win = elig[1];
    if (elig == 2'b11) win = (FIXED_PRIO != 0) ? 1'b0 : ~gid_q;
  end

  // slot sequencing: grant on phi2, one strobe clk, one capture clk
  always_comb begin
    state_d = state_q;
    cs_n_d  = 1'b1;
    rw_d    = rw_q;
    rs_d    = rs_q;
    db_d    = db_q;
    gid_d   = gid_q;
    case (state_q)
      IDLE: begin
        if (phi2 && (elig != '0)) begin
          rw_d    = rw_m[win];
          rs_d    = rs_m[win];
          db_d    = wd_m[win];
          gid_d   = win;
          cs_n_d  = 1'b0;
          state_d = STROBE;
        end
      end
      STROBE:  state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and CIA-facing registers; bus fields hold from grant to next grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      rw_q    <= 1'b1;
      rs_q    <= 4'h0;
      db_q    <= 8'h00;
      gid_q   <= 1'b1;     // makes m0 the first round-robin tie winner
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      gid_q   <= gid_d;
    end
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    assign done[i] = (state_q == CAPTURE) && (gid_q == (i != 0));
    cia_bus_arbiter_port u_port (
      .clk     (clk),
      .reset_n (reset_n),
      .done_i  (done[i]),
      .rd_i    (rw_q),
      .db_i    (bus.cia_db_out),
      .ack_o   (ack[i]),
      .rdata_o (rdata[i])
    );
  end

  assign bus.m0_ack    = ack[0];
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_ack    = ack[1];
  assign bus.m1_rdata  = rdata[1];
  assign bus.cia_cs_n  = cs_n_q;
  assign bus.cia_rw    = rw_q;
  assign bus.cia_rs    = rs_q;
  assign bus.cia_db_in = db_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = gid_q;
endmodule
